// File: rtl/muldiv_writeback_unit.sv
// Iterative 16-bit unsigned multiply/divide unit feeding the register file write port.
// One operation per accepted start; result is written back for exactly one cycle.
module muldiv_writeback_unit #(
    parameter int unsigned WordLen    = 16,
    parameter int unsigned RegAddrLen = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            op,
    input  logic [WordLen-1:0]    operandA,
    input  logic [WordLen-1:0]    operandB,
    input  logic [RegAddrLen-1:0] destReg,
    output logic                  busy,
    output logic                  done,
    output logic                  regWrite,
    output logic [RegAddrLen-1:0] writeRegister,
    output logic [WordLen-1:0]    writeData
);

    localparam int unsigned CntW = $clog2(WordLen);
    localparam logic [CntW-1:0] LastStep = CntW'(WordLen - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StWb
    } state_e;

    state_e                state_q, state_d;
    logic [CntW-1:0]       cnt_q, cnt_d;
    logic [1:0]            op_q, op_d;
    logic [WordLen-1:0]    b_q, b_d;
    logic [RegAddrLen-1:0] dest_q, dest_d;
    // hi holds the product high half or the partial remainder; lo holds the
    // product low half or the dividend shifting out / quotient shifting in.
    logic [WordLen-1:0]    hi_q, hi_d;
    logic [WordLen-1:0]    lo_q, lo_d;
    logic [WordLen-1:0]    wdata_q, wdata_d;
    logic [RegAddrLen-1:0] wreg_q, wreg_d;

    logic [WordLen:0]      mul_sum;
    logic [WordLen:0]      div_shift;
    logic [WordLen-1:0]    div_sub;
    logic                  div_ok;

    assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
    assign div_shift = {hi_q, lo_q[WordLen-1]};
    assign div_ok    = (div_shift >= {1'b0, b_q});
    // Only taken when no borrow, so the difference always fits in WordLen bits.
    assign div_sub   = WordLen'(div_shift - {1'b0, b_q});

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        b_d     = b_q;
        dest_d  = dest_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        wdata_d = wdata_q;
        wreg_d  = wreg_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    op_d   = op;
                    b_d    = operandB;
                    dest_d = destReg;
                    cnt_d  = '0;
                    hi_d   = '0;
                    lo_d   = operandA;
                    if (op[1] && (operandB == '0)) begin
                        state_d = StWb;
                        wdata_d = op[0] ? operandA : '1;
                        wreg_d  = destReg;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                cnt_d = cnt_q + CntW'(1);
                if (op_q[1]) begin
                    hi_d = div_ok ? div_sub : div_shift[WordLen-1:0];
                    lo_d = {lo_q[WordLen-2:0], div_ok};
                end else begin
                    hi_d = mul_sum[WordLen:1];
                    lo_d = {mul_sum[0], lo_q[WordLen-1:1]};
                end
                if (cnt_q == LastStep) begin
                    state_d = StWb;
                    // MULHU and REMU take the high/remainder half, MUL and DIVU the low/quotient.
                    wdata_d = op_q[0] ? hi_d : lo_d;
                    wreg_d  = dest_q;
                end
            end
            StWb: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            op_q    <= '0;
            b_q     <= '0;
            dest_q  <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            wdata_q <= '0;
            wreg_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            b_q     <= b_d;
            dest_q  <= dest_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            wdata_q <= wdata_d;
            wreg_q  <= wreg_d;
        end
    end

    assign busy          = (state_q != StIdle);
    assign done          = (state_q == StWb);
    // Register 0 is hardwired to zero, so its writeback is suppressed.
    assign regWrite      = done && (wreg_q != '0);
    assign writeRegister = wreg_q;
    assign writeData     = wdata_q;

endmodule

// File: tb/tb_muldiv_writeback_unit.sv
// Scoreboard bench for muldiv_writeback_unit: directed vectors push expected
// writebacks; a negedge monitor pops and compares on every done pulse.
module tb_muldiv_writeback_unit;

    localparam logic [1:0] OpMul   = 2'b00;
    localparam logic [1:0] OpMulhu = 2'b01;
    localparam logic [1:0] OpDivu  = 2'b10;
    localparam logic [1:0] OpRemu  = 2'b11;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [15:0] operandA;
    logic [15:0] operandB;
    logic [2:0]  destReg;
    logic        busy;
    logic        done;
    logic        regWrite;
    logic [2:0]  writeRegister;
    logic [15:0] writeData;

    typedef struct {
        logic        rw;
        logic [2:0]  wr;
        logic [15:0] wd;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    muldiv_writeback_unit #(
        .WordLen   (16),
        .RegAddrLen(3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .op           (op),
        .operandA     (operandA),
        .operandB     (operandB),
        .destReg      (destReg),
        .busy         (busy),
        .done         (done),
        .regWrite     (regWrite),
        .writeRegister(writeRegister),
        .writeData    (writeData)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (regWrite && !done) begin
                chk("regwrite_without_done", 32'(regWrite), 32'd0);
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("regWrite", 32'(regWrite), 32'(e.rw));
                    chk("writeRegister", 32'(writeRegister), 32'(e.wr));
                    chk("writeData", 32'(writeData), 32'(e.wd));
                    chk("wb_cycle", 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    task automatic issue(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                         input logic [2:0] d);
        @(negedge clk);
        start    = 1'b1;
        op       = o;
        operandA = a;
        operandB = b;
        destReg  = d;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic run_op(input logic [1:0] o, input logic [15:0] a, input logic [15:0] b,
                          input logic [2:0] d, input logic [15:0] expd, input bit interfere);
        exp_t e;
        bit   fell;
        issue(o, a, b, d);
        e.rw  = (d != 3'd0);
        e.wr  = d;
        e.wd  = expd;
        e.cyc = (o[1] && (b == 16'd0)) ? cyc : cyc + 16;
        exp_q.push_back(e);
        chk("busy_after_accept", 32'(busy), 32'd1);
        if (interfere) begin
            repeat (5) @(negedge clk);
            start    = 1'b1;
            op       = OpRemu;
            operandA = 16'h4321;
            operandB = 16'h0000;
            destReg  = 3'd6;
            @(negedge clk);
            start = 1'b0;
        end
        fell = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (!busy) begin
                fell = 1'b1;
                break;
            end
        end
        if (!fell) chk("busy_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        op       = 2'b00;
        operandA = 16'h0;
        operandB = 16'h0;
        destReg  = 3'd0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_regWrite", 32'(regWrite), 32'd0);
        chk("rst_writeRegister", 32'(writeRegister), 32'd0);
        chk("rst_writeData", 32'(writeData), 32'd0);
        rst = 1'b0;

        run_op(OpMul,   16'h0123, 16'h0010, 3'd3, 16'h1230, 1'b0);
        run_op(OpMulhu, 16'hFFFF, 16'hFFFF, 3'd1, 16'hFFFE, 1'b0);
        run_op(OpMul,   16'hFFFF, 16'hFFFF, 3'd2, 16'h0001, 1'b0);
        run_op(OpDivu,  16'd100,  16'd7,    3'd5, 16'h000E, 1'b0);
        run_op(OpRemu,  16'd100,  16'd7,    3'd4, 16'h0002, 1'b0);
        run_op(OpDivu,  16'h8000, 16'h0001, 3'd7, 16'h8000, 1'b0);
        run_op(OpDivu,  16'h1234, 16'h0000, 3'd6, 16'hFFFF, 1'b0);
        run_op(OpRemu,  16'h1234, 16'h0000, 3'd3, 16'h1234, 1'b0);
        run_op(OpMul,   16'd3,    16'd4,    3'd0, 16'h000C, 1'b0);
        run_op(OpMul,   16'd5,    16'd6,    3'd2, 16'h001E, 1'b1);

        // Abort mid-RUN: reset sampled at the 8th RUN edge, nothing is written.
        issue(OpMul, 16'h00FF, 16'h00FF, 3'd5);
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_regWrite", 32'(regWrite), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        run_op(OpMul, 16'd2, 16'd3, 3'd1, 16'h0006, 1'b0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
